four_stage_pipeline: RTL and testbench
======================================

// Module: four_stage_pipeline
// PURPOSE
//  Four-stage register-ALU-memory pipeline. Each cycle it can accept one instruction:
//  - read two operands from a 16x16 register bank;
//  - compute a 16-bit ALU result;
//  - write the result back to the register bank;
//  - store the result into a 256x16 data memory.
//  Used as a datapath/teaching core; no hazard handling.
// PARAMETERS
//  DW     16   data width of regbank, ALU and mem
//  RA_W   4    register address width (16 registers)
//  MA_W   8    memory address width (256 words)
// PORTS
//  clk       in   1     single clock, all state updates on posedge
//  rst_n     in   1     asynchronous, active-low reset
//  in_valid  in   1     instruction present on inputs this cycle
//  ra1       in   4     source register 1 (operand A)
//  ra2       in   4     source register 2 (operand B)
//  rwa       in   4     destination register for write-back
//  ma        in   8     destination memory address for store
//  func      in   4     ALU operation select
//  C         out  16    result of instruction leaving stage 3 (registered)
//  out_valid out  1     C holds a valid result
// BEHAVIOUR
//  - Storage arrays are named regbank[0:15] and mem[0:255], both 16-bit.
//    They are not cleared by reset, so benches may preload them hierarchically.
//  - S1 (edge k): if in_valid, latch A=regbank[ra1], B=regbank[ra2], func, rwa, ma, v1=1; else v1=0.
//  - S2 (edge k+1): Z2 = ALU(A,B,func); forward rwa, ma; v2=v1.
//  - S3 (edge k+2): if v2, regbank[rwa2]<=Z2; C<=Z2; out_valid<=v2; forward Z, ma.
//  - S4 (edge k+3): if v3, mem[ma3]<=Z3.
//  - Throughput is 1 instruction/cycle. C and out_valid are valid 3 edges after the input edge.
//  - ALU func encoding (16-bit results, all arithmetic modulo 2^16):
//    - 0 A+B
//    - 1 A-B
//    - 2 A*B (low 16 bits)
//    - 3 A
//    - 4 B
//    - 5 A&B
//    - 6 A|B
//    - 7 A^B
//    - 8 -A
//    - 9 -B
//    - 10 A>>1 (logical)
//    - 11 A<<1
//    - 12-15 produce 16'h0000
//  - No forwarding or interlock. An S1 read on the same edge as an S3 write to the same register returns the OLD value.
//  - Writes from a later instruction overwrite the same register/address in program order.
//  - Reset (async, rst_n=0): all pipeline registers and valid bits go to 0; C=0, out_valid=0.
//    Instructions in flight are discarded with no partial regbank/mem writes.
//    regbank/mem contents are retained.
//  - Release of reset is synchronized so that the first capture occurs on the first posedge with rst_n=1.
// TESTING
//  Preload regbank[i]=i*i for all 16 registers, then issue one instruction per cycle:
//  - ra1=2,ra2=7,func=0,rwa=12,ma=145 -> C=53, regbank[12]=53, mem[145]=53.
//  - ra1=1,ra2=4,func=4,rwa=13,ma=169 -> C=16, mem[169]=16.
//    ra1=9,ra2=5,func=3,rwa=11,ma=132 -> C=81, mem[132]=81.
//  - ra1=6,ra2=2,func=7,rwa=14,ma=140 -> C=32 (36^4), mem[140]=32.
//    Check that the four results appear on consecutive cycles.
//  - Edge cases:
//    - func=1 with A=0,B=1 -> C=16'hFFFF.
//    - regbank[15]=300, func=2, ra1=ra2=15 -> C=24464 (90000 mod 65536).
//    - func=13 -> C=0.
//  - Hazard: instr writes r3, next cycle instr reads r3 -> second instr sees the old r3.
//  - Reset: assert rst_n low with 3 instrs in flight -> out_valid=0 immediately, C=0.
//    No further regbank/mem writes occur; preloaded data is unchanged.

Source files
------------

// File: rtl/four_stage_pipeline_if.sv
// Instruction-in / result-out bundle for the four-stage register-ALU-memory pipeline.
// The master drives instructions and the slave (the pipeline) returns results.
interface four_stage_pipeline_if #(
    parameter int DW   = 16,
    parameter int RA_W = 4,
    parameter int MA_W = 8
);
    logic            in_valid;
    logic [RA_W-1:0] ra1;
    logic [RA_W-1:0] ra2;
    logic [RA_W-1:0] rwa;
    logic [MA_W-1:0] ma;
    logic [3:0]      func;
    logic [DW-1:0]   C;
    logic            out_valid;

    modport master (
        output in_valid, ra1, ra2, rwa, ma, func,
        input  C, out_valid
    );

    modport slave (
        input  in_valid, ra1, ra2, rwa, ma, func,
        output C, out_valid
    );
endinterface

// File: rtl/four_stage_pipeline.sv
// Four-stage pipeline: S1 operand read, S2 ALU, S3 register write-back and result
// output, S4 memory store. One instruction per cycle; no hazard handling.
module four_stage_pipeline #(
    parameter int DW   = 16,
    parameter int RA_W = 4,
    parameter int MA_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    four_stage_pipeline_if.slave bus
);
    logic [DW-1:0] regbank [0:(1<<RA_W)-1];
    logic [DW-1:0] mem     [0:(1<<MA_W)-1];

    // vld_q[n] marks a live instruction in the stage-n registers
    logic [3:1]      vld_q, vld_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]      func1_q, func1_d;
    logic [RA_W-1:0] rwa1_q, rwa1_d, rwa2_q, rwa2_d;
    logic [MA_W-1:0] ma1_q, ma1_d, ma2_q, ma2_d, ma3_q, ma3_d;
    logic [DW-1:0]   z2_q, z2_d, c_q, c_d;
    logic [DW-1:0]   alu_z;

    always_comb begin
        alu_z = '0;
        case (func1_q)
            4'd0:  alu_z = a_q + b_q;
            4'd1:  alu_z = a_q - b_q;
            4'd2:  alu_z = a_q * b_q;
            4'd3:  alu_z = a_q;
            4'd4:  alu_z = b_q;
            4'd5:  alu_z = a_q & b_q;
            4'd6:  alu_z = a_q | b_q;
            4'd7:  alu_z = a_q ^ b_q;
            4'd8:  alu_z = -a_q;
            4'd9:  alu_z = -b_q;
            4'd10: alu_z = a_q >> 1;
            4'd11: alu_z = a_q << 1;
            default: alu_z = '0;
        endcase
    end

    // Stage payloads only load behind a live instruction so idle cycles hold state
    always_comb begin
        vld_d   = {vld_q[2], vld_q[1], bus.in_valid};
        a_d     = bus.in_valid ? regbank[bus.ra1] : a_q;
        b_d     = bus.in_valid ? regbank[bus.ra2] : b_q;
        func1_d = bus.in_valid ? bus.func : func1_q;
        rwa1_d  = bus.in_valid ? bus.rwa  : rwa1_q;
        ma1_d   = bus.in_valid ? bus.ma   : ma1_q;
        z2_d    = vld_q[1] ? alu_z  : z2_q;
        rwa2_d  = vld_q[1] ? rwa1_q : rwa2_q;
        ma2_d   = vld_q[1] ? ma1_q  : ma2_q;
        c_d     = vld_q[2] ? z2_q   : c_q;
        ma3_d   = vld_q[2] ? ma2_q  : ma3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            func1_q <= '0;
            rwa1_q  <= '0;
            ma1_q   <= '0;
            z2_q    <= '0;
            rwa2_q  <= '0;
            ma2_q   <= '0;
            c_q     <= '0;
            ma3_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            a_q     <= a_d;
            b_q     <= b_d;
            func1_q <= func1_d;
            rwa1_q  <= rwa1_d;
            ma1_q   <= ma1_d;
            z2_q    <= z2_d;
            rwa2_q  <= rwa2_d;
            ma2_q   <= ma2_d;
            c_q     <= c_d;
            ma3_q   <= ma3_d;
        end
    end

    // Storage is unreset and left open to hierarchical preload, so it sits in a plain
    // clocked block; writes are gated by valid bits that reset clears asynchronously.
    always @(posedge clk) begin
        if (vld_q[2]) regbank[rwa2_q] <= z2_q;
        if (vld_q[3]) mem[ma3_q]      <= c_q;
    end

    assign bus.C         = c_q;
    assign bus.out_valid = vld_q[3];
endmodule

// File: tb/tb_four_stage_pipeline.sv
// Bench for four_stage_pipeline: directed spec examples plus random instructions,
// checked against an instruction-level model with delayed register/memory commits.
module tb_four_stage_pipeline;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    four_stage_pipeline_if bus ();
    four_stage_pipeline dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int          e;
        int          addr;
        logic [15:0] d;
    } pend_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          edge_cnt = 0;
    logic [15:0] m_rb  [0:15];
    logic [15:0] m_mem [0:255];
    pend_t       rb_q[$];
    pend_t       mem_q[$];
    bit          exp_v [0:8191];
    logic [15:0] exp_c [0:8191];
    logic [15:0] obs_c [0:8191];
    bit          obs_v [0:8191];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     tag, obs, obs, exp, exp, edge_cnt);
        end
    endtask

    function automatic logic [15:0] alu(input int a, input int b, input int f);
        int r;
        case (f)
            0:  r = a + b;
            1:  r = a - b + 65536;
            2:  r = (a * b) % 65536;
            3:  r = a;
            4:  r = b;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = 65536 - a;
            9:  r = 65536 - b;
            10: r = a / 2;
            11: r = a * 2;
            default: r = 0;
        endcase
        return 16'(r % 65536);
    endfunction

    // Apply every modelled write whose commit edge is at or before lim
    task automatic commit_upto(input int lim);
        while (rb_q.size() > 0 && rb_q[0].e <= lim) begin
            m_rb[rb_q[0].addr] = rb_q[0].d;
            void'(rb_q.pop_front());
        end
        while (mem_q.size() > 0 && mem_q[0].e <= lim) begin
            m_mem[mem_q[0].addr] = mem_q[0].d;
            void'(mem_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        obs_v[edge_cnt] = bus.out_valid;
        obs_c[edge_cnt] = bus.C;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_v[edge_cnt]});
        if (exp_v[edge_cnt]) chk("C", {16'd0, bus.C}, {16'd0, exp_c[edge_cnt]});
        if (!rst_n) chk("C_in_reset", {16'd0, bus.C}, 32'd0);
    endtask

    // Called at a negedge: present one instruction and model it against the next edge
    task automatic issue(input bit v, input int r1, input int r2, input int f,
                         input int rw, input int m);
        int n;
        logic [15:0] z;
        n = edge_cnt + 1;
        bus.in_valid = v;
        bus.ra1 = 4'(r1);
        bus.ra2 = 4'(r2);
        bus.func = 4'(f);
        bus.rwa = 4'(rw);
        bus.ma = 8'(m);
        if (v && rst_n) begin
            commit_upto(n - 1);
            z = alu(int'(m_rb[r1]), int'(m_rb[r2]), f);
            rb_q.push_back('{e: n + 2, addr: rw, d: z});
            mem_q.push_back('{e: n + 3, addr: m, d: z});
            exp_v[n + 2] = 1'b1;
            exp_c[n + 2] = z;
        end
        tick();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) issue(1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic cmp_storage(input string tag);
        commit_upto(edge_cnt);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_regbank[%0d]", tag, i), {16'd0, dut.regbank[i]}, {16'd0, m_rb[i]});
        for (int i = 0; i < 256; i++)
            chk($sformatf("%s_mem[%0d]", tag, i), {16'd0, dut.mem[i]}, {16'd0, m_mem[i]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        for (int i = 0; i < 8192; i++) begin
            exp_v[i] = 1'b0;
            exp_c[i] = '0;
        end
        bus.in_valid = 1'b0;
        bus.ra1 = '0; bus.ra2 = '0; bus.rwa = '0; bus.ma = '0; bus.func = '0;
        for (int i = 0; i < 16; i++) begin
            dut.regbank[i] = 16'(i * i);
            m_rb[i] = 16'(i * i);
        end
        for (int i = 0; i < 256; i++) begin
            dut.mem[i] = 16'(i * 3 + 7);
            m_mem[i] = 16'(i * 3 + 7);
        end
        idle(2);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_C", {16'd0, bus.C}, 32'd0);
        rst_n = 1'b1;

        // Spec examples back to back
        t0 = edge_cnt;
        issue(1, 2, 7, 0, 12, 145);
        issue(1, 1, 4, 4, 13, 169);
        issue(1, 9, 5, 3, 11, 132);
        issue(1, 6, 2, 7, 14, 140);
        idle(4);
        chk("ex0_C", {16'd0, obs_c[t0 + 3]}, 32'd53);
        chk("ex1_C", {16'd0, obs_c[t0 + 4]}, 32'd16);
        chk("ex2_C", {16'd0, obs_c[t0 + 5]}, 32'd81);
        chk("ex3_C", {16'd0, obs_c[t0 + 6]}, 32'd32);
        chk("ex_consecutive", {28'd0, obs_v[t0 + 2], obs_v[t0 + 3], obs_v[t0 + 6], obs_v[t0 + 7]},
            32'b0110);
        chk("ex_r12", {16'd0, dut.regbank[12]}, 32'd53);
        chk("ex_mem145", {16'd0, dut.mem[145]}, 32'd53);
        chk("ex_mem169", {16'd0, dut.mem[169]}, 32'd16);
        chk("ex_mem132", {16'd0, dut.mem[132]}, 32'd81);
        chk("ex_mem140", {16'd0, dut.mem[140]}, 32'd32);

        // Boundary cases: underflow, multiply wrap, unused func codes
        dut.regbank[15] = 16'd300;
        m_rb[15] = 16'd300;
        t0 = edge_cnt;
        issue(1, 0, 1, 1, 8, 10);
        issue(1, 15, 15, 2, 9, 11);
        issue(1, 4, 5, 13, 10, 12);
        idle(3);
        chk("sub_wrap_C", {16'd0, obs_c[t0 + 3]}, 32'hFFFF);
        chk("mul_wrap_C", {16'd0, obs_c[t0 + 4]}, 32'd24464);
        chk("func13_C", {16'd0, obs_c[t0 + 5]}, 32'd0);

        // Read-after-write one cycle apart sees the old register value
        t0 = edge_cnt;
        issue(1, 3, 3, 0, 3, 20);
        issue(1, 3, 0, 3, 6, 21);
        idle(3);
        chk("hazard_first_C", {16'd0, obs_c[t0 + 3]}, 32'd18);
        chk("hazard_old_r3", {16'd0, obs_c[t0 + 4]}, 32'd9);
        chk("hazard_r3_after", {16'd0, dut.regbank[3]}, 32'd18);

        for (int i = 0; i < 250; i++)
            issue($urandom_range(0, 9) < 8, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
        idle(4);
        cmp_storage("rand");

        // Reset with three instructions in flight
        issue(1, 2, 3, 0, 1, 50);
        issue(1, 4, 5, 6, 2, 51);
        issue(1, 6, 7, 7, 4, 52);
        commit_upto(edge_cnt);
        rb_q.delete();
        mem_q.delete();
        for (int i = edge_cnt + 1; i <= edge_cnt + 4; i++) exp_v[i] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_C", {16'd0, bus.C}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(3);
        cmp_storage("post_rst");

        for (int i = 0; i < 40; i++)
            issue(1'b1, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
        idle(4);
        cmp_storage("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
